// File: rtl/sr_reg_pkg.sv
// ---------------------------------------------------------------------------
// sr_reg_pkg
// Shared encodings for the configurable bistable register bank.
//   mode_e : per-bank operating mode (SR, JK, D, T)
//   pol_e  : resolution of the SR S=R=1 input combination
// ---------------------------------------------------------------------------
package sr_reg_pkg;

    typedef enum logic [1:0] {
        MODE_SR = 2'd0,
        MODE_JK = 2'd1,
        MODE_D  = 2'd2,
        MODE_T  = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        POL_HOLD = 2'd0,
        POL_SET  = 2'd1,
        POL_RST  = 2'd2,
        POL_TGL  = 2'd3
    } pol_e;

endpackage : sr_reg_pkg

// File: rtl/sr_ff_cell.sv
// ---------------------------------------------------------------------------
// sr_ff_cell
// One channel of the register bank: next-state function plus q/changed flops.
// Ports:
//   clk, rst   rising-edge clock, asynchronous active-high reset
//   en         update enable; 0 holds q and forces changed low
//   mode       bank mode (see mode_e)
//   a, b       S/J/D/T and R/K inputs for this channel
//   q          stored state
//   changed    registered: high for the cycle after an edge that changed q
//   conflict   combinational: this edge is an SR update with S=R=1
// ---------------------------------------------------------------------------
module sr_ff_cell
    import sr_reg_pkg::*;
#(
    parameter logic [1:0] CONFLICT_POL = POL_HOLD,
    parameter logic       RESET_VAL    = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [1:0] mode,
    input  logic       a,
    input  logic       b,
    output logic       q,
    output logic       changed,
    output logic       conflict
);

    localparam pol_e POL = pol_e'(CONFLICT_POL);

    logic q_next;

    // NOTE: q_next is given a default before the case so every path assigns
    // it; otherwise an unlisted combination would infer a latch.
    always_comb begin
        q_next = q;
        case (mode)
            MODE_SR: begin
                case ({a, b})
                    2'b01:   q_next = 1'b0;
                    2'b10:   q_next = 1'b1;
                    2'b11: begin
                        case (POL)
                            POL_SET: q_next = 1'b1;
                            POL_RST: q_next = 1'b0;
                            POL_TGL: q_next = ~q;
                            default: q_next = q;
                        endcase
                    end
                    default: q_next = q;
                endcase
            end
            MODE_JK: begin
                case ({a, b})
                    2'b01:   q_next = 1'b0;
                    2'b10:   q_next = 1'b1;
                    2'b11:   q_next = ~q;
                    default: q_next = q;
                endcase
            end
            MODE_D:  q_next = a;
            default: q_next = q ^ a;  // T
        endcase
    end

    assign conflict = en && (mode == MODE_SR) && a && b;

    // NOTE: state flops use non-blocking assignments so every flop samples
    // the pre-edge value of q regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q       <= RESET_VAL;
            changed <= 1'b0;
        end else begin
            if (en) begin
                q <= q_next;
            end
            changed <= en & (q_next ^ q);
        end
    end

endmodule : sr_ff_cell

// File: rtl/sr_reg_bank.sv
// ---------------------------------------------------------------------------
// sr_reg_bank
// WIDTH-channel bank of clocked bistables, run-time selectable as SR/JK/D/T,
// with sticky per-channel SR conflict flags and a saturating conflict counter.
// Ports:
//   clk, rst       rising-edge clock, asynchronous active-high reset
//   en             global update enable
//   mode           0 SR, 1 JK, 2 D, 3 T (all channels)
//   a, b           per-channel S/J/D/T and R/K inputs
//   clr_conflict   clears conflict_flag / conflict_cnt (a same-edge conflict wins)
//   q, qn          stored state and its combinational complement
//   changed        per-channel "q changed on the last edge"
//   conflict_flag  sticky per-channel SR S=R=1 indicator
//   conflict_cnt   number of edges with at least one conflicting channel
// ---------------------------------------------------------------------------
module sr_reg_bank
    import sr_reg_pkg::*;
#(
    parameter int               WIDTH        = 8,
    parameter logic [WIDTH-1:0] RESET_VAL    = '0,
    parameter logic [1:0]       CONFLICT_POL = POL_HOLD,
    parameter int               CNT_W        = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             clr_conflict,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qn,
    output logic [WIDTH-1:0] changed,
    output logic [WIDTH-1:0] conflict_flag,
    output logic [CNT_W-1:0] conflict_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [WIDTH-1:0] cell_conflict;
    logic             any_conflict;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        sr_ff_cell #(
            .CONFLICT_POL (CONFLICT_POL),
            .RESET_VAL    (RESET_VAL[i])
        ) u_cell (
            .clk      (clk),
            .rst      (rst),
            .en       (en),
            .mode     (mode),
            .a        (a[i]),
            .b        (b[i]),
            .q        (q[i]),
            .changed  (changed[i]),
            .conflict (cell_conflict[i])
        );
    end

    assign qn           = ~q;
    assign any_conflict = |cell_conflict;

    // A clear on the same edge as a new conflict leaves only the new event
    // recorded; cell_conflict is already zero whenever en=0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            conflict_flag <= '0;
            conflict_cnt  <= '0;
        end else if (clr_conflict) begin
            conflict_flag <= cell_conflict;
            conflict_cnt  <= any_conflict ? CNT_W'(1) : '0;
        end else begin
            conflict_flag <= conflict_flag | cell_conflict;
            if (any_conflict && (conflict_cnt != CNT_MAX)) begin
                conflict_cnt <= conflict_cnt + 1'b1;
            end
        end
    end

endmodule : sr_reg_bank

// File: tb/tb_sr_reg_bank.sv
// ---------------------------------------------------------------------------
// tb_sr_reg_bank
// Four 8-bit instances (one per conflict policy, RESET_VAL 0, 8-bit counter)
// plus one instance with CNT_W=2 and RESET_VAL 8'h3C, all sharing inputs.
// ---------------------------------------------------------------------------
module tb_sr_reg_bank;
    import sr_reg_pkg::*;

    localparam int W  = 8;
    localparam int NI = 5;

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic [1:0]   mode;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         clr;

    logic [W-1:0] q   [NI];
    logic [W-1:0] qn  [NI];
    logic [W-1:0] ch  [NI];
    logic [W-1:0] fl  [NI];
    logic [7:0]   cnt [4];
    logic [1:0]   cnt2;

    always #5 clk = ~clk;

    for (genvar p = 0; p < 4; p++) begin : g_pol
        sr_reg_bank #(
            .WIDTH(W), .RESET_VAL(8'h00), .CONFLICT_POL(2'(p)), .CNT_W(8)
        ) u_dut (
            .clk(clk), .rst(rst), .en(en), .mode(mode), .a(a), .b(b),
            .clr_conflict(clr), .q(q[p]), .qn(qn[p]), .changed(ch[p]),
            .conflict_flag(fl[p]), .conflict_cnt(cnt[p])
        );
    end

    sr_reg_bank #(
        .WIDTH(W), .RESET_VAL(8'h3C), .CONFLICT_POL(2'd0), .CNT_W(2)
    ) u_dut_c2 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .a(a), .b(b),
        .clr_conflict(clr), .q(q[4]), .qn(qn[4]), .changed(ch[4]),
        .conflict_flag(fl[4]), .conflict_cnt(cnt2)
    );

    // ---------------- reference model ----------------
    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    logic [W-1:0] m_q   [NI];
    logic [W-1:0] m_ch  [NI];
    logic [W-1:0] m_fl  [NI];
    int           m_cnt [NI];

    function automatic int inst_pol(int i);
        return (i < 4) ? i : 0;
    endfunction

    function automatic int inst_max(int i);
        return (i < 4) ? 255 : 3;
    endfunction

    function automatic logic [W-1:0] inst_rst(int i);
        return (i < 4) ? 8'h00 : 8'h3C;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NI; i++) begin
            m_q[i]   = inst_rst(i);
            m_ch[i]  = '0;
            m_fl[i]  = '0;
            m_cnt[i] = 0;
        end
    endtask

    // Applies the documented per-channel rules bit by bit.
    task automatic model_edge();
        for (int i = 0; i < NI; i++) begin
            logic [W-1:0] nq;
            logic [W-1:0] conf;
            nq   = m_q[i];
            conf = '0;
            if (en) begin
                for (int k = 0; k < W; k++) begin
                    case (mode)
                        MODE_SR: begin
                            if (a[k] && b[k]) begin
                                conf[k] = 1'b1;
                                case (inst_pol(i))
                                    1: nq[k] = 1'b1;
                                    2: nq[k] = 1'b0;
                                    3: nq[k] = ~m_q[i][k];
                                    default: nq[k] = m_q[i][k];
                                endcase
                            end else if (a[k]) nq[k] = 1'b1;
                            else if (b[k])     nq[k] = 1'b0;
                        end
                        MODE_JK: begin
                            if (a[k] && b[k]) nq[k] = ~m_q[i][k];
                            else if (a[k])    nq[k] = 1'b1;
                            else if (b[k])    nq[k] = 1'b0;
                        end
                        MODE_D:  nq[k] = a[k];
                        default: if (a[k]) nq[k] = ~m_q[i][k];
                    endcase
                end
            end
            m_ch[i] = nq ^ m_q[i];
            m_q[i]  = nq;
            if (clr) begin
                m_fl[i]  = conf;
                m_cnt[i] = (conf != 0) ? 1 : 0;
            end else begin
                m_fl[i] = m_fl[i] | conf;
                if (conf != 0 && m_cnt[i] < inst_max(i)) m_cnt[i]++;
            end
        end
    endtask

    // ---------------- checking helpers ----------------
    task automatic check(string name, logic [7:0] act, logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] dut_cnt(int i);
        return (i < 4) ? cnt[i] : 8'(cnt2);
    endfunction

    task automatic check_model(string tag);
        for (int i = 0; i < NI; i++) begin
            check($sformatf("%s.q[%0d]", tag, i),   q[i],       m_q[i]);
            check($sformatf("%s.qn[%0d]", tag, i),  qn[i],      ~m_q[i]);
            check($sformatf("%s.chg[%0d]", tag, i), ch[i],      m_ch[i]);
            check($sformatf("%s.flg[%0d]", tag, i), fl[i],      m_fl[i]);
            check($sformatf("%s.cnt[%0d]", tag, i), dut_cnt(i), 8'(m_cnt[i]));
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic drive(logic e, logic [1:0] m, logic [7:0] va, logic [7:0] vb, logic c);
        en = e; mode = m; a = va; b = vb; clr = c;
    endtask

    // Asserts reset mid-cycle, checks the asynchronous effect, then releases
    // it away from an edge so the next edge is a normal update.
    task automatic reset_pulse(string tag);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_model(tag);
        drive(1'b0, MODE_SR, 8'h00, 8'h00, 1'b0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic       en;
        logic [1:0] mode;
        logic [7:0] a;
        logic [7:0] b;
        logic       clr;
        logic [7:0] q   [4];
        logic [7:0] chg [4];
        logic [7:0] flg;
        logic [7:0] cnt;
    } vec_t;

    vec_t tbl [12];

    initial begin
        tbl[0]  = '{1'b1, MODE_SR, 8'h0F, 8'hF0, 1'b0, '{8'h0F, 8'h0F, 8'h0F, 8'h0F}, '{8'h0F, 8'h0F, 8'h0F, 8'h0F}, 8'h00, 8'd0};
        tbl[1]  = '{1'b1, MODE_SR, 8'h00, 8'h00, 1'b0, '{8'h0F, 8'h0F, 8'h0F, 8'h0F}, '{8'h00, 8'h00, 8'h00, 8'h00}, 8'h00, 8'd0};
        tbl[2]  = '{1'b1, MODE_SR, 8'hFF, 8'hFF, 1'b0, '{8'h0F, 8'hFF, 8'h00, 8'hF0}, '{8'h00, 8'hF0, 8'h0F, 8'hFF}, 8'hFF, 8'd1};
        tbl[3]  = '{1'b1, MODE_D,  8'h00, 8'hFF, 1'b0, '{8'h00, 8'h00, 8'h00, 8'h00}, '{8'h0F, 8'hFF, 8'h00, 8'hF0}, 8'hFF, 8'd1};
        tbl[4]  = '{1'b1, MODE_JK, 8'hFF, 8'hFF, 1'b0, '{8'hFF, 8'hFF, 8'hFF, 8'hFF}, '{8'hFF, 8'hFF, 8'hFF, 8'hFF}, 8'hFF, 8'd1};
        tbl[5]  = '{1'b1, MODE_JK, 8'hFF, 8'hFF, 1'b0, '{8'h00, 8'h00, 8'h00, 8'h00}, '{8'hFF, 8'hFF, 8'hFF, 8'hFF}, 8'hFF, 8'd1};
        tbl[6]  = '{1'b1, MODE_T,  8'h01, 8'hFF, 1'b0, '{8'h01, 8'h01, 8'h01, 8'h01}, '{8'h01, 8'h01, 8'h01, 8'h01}, 8'hFF, 8'd1};
        tbl[7]  = '{1'b1, MODE_D,  8'hA5, 8'h00, 1'b0, '{8'hA5, 8'hA5, 8'hA5, 8'hA5}, '{8'hA4, 8'hA4, 8'hA4, 8'hA4}, 8'hFF, 8'd1};
        tbl[8]  = '{1'b0, MODE_SR, 8'hFF, 8'hFF, 1'b0, '{8'hA5, 8'hA5, 8'hA5, 8'hA5}, '{8'h00, 8'h00, 8'h00, 8'h00}, 8'hFF, 8'd1};
        tbl[9]  = '{1'b1, MODE_SR, 8'h00, 8'h00, 1'b1, '{8'hA5, 8'hA5, 8'hA5, 8'hA5}, '{8'h00, 8'h00, 8'h00, 8'h00}, 8'h00, 8'd0};
        tbl[10] = '{1'b1, MODE_SR, 8'h03, 8'h03, 1'b1, '{8'hA5, 8'hA7, 8'hA4, 8'hA6}, '{8'h00, 8'h02, 8'h01, 8'h03}, 8'h03, 8'd1};
        tbl[11] = '{1'b1, MODE_SR, 8'h00, 8'h00, 1'b0, '{8'hA5, 8'hA7, 8'hA4, 8'hA6}, '{8'h00, 8'h00, 8'h00, 8'h00}, 8'h03, 8'd1};
    end

    // ---------------- main sequence ----------------
    initial begin
        rst = 1'b1;
        drive(1'b0, MODE_SR, 8'h00, 8'h00, 1'b0);
        model_reset();
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_model("rst_init");

        // Junk activity, then an asynchronous reset in the middle of a cycle.
        drive(1'b1, MODE_JK, 8'h5A, 8'h3C, 1'b0);
        step();
        drive(1'b1, MODE_SR, 8'hFF, 8'h0F, 1'b0);
        step();
        drive(1'b1, MODE_T, 8'hC3, 8'h00, 1'b0);
        reset_pulse("rst_async");

        // Table: expected values written out by hand.
        for (int r = 0; r < 12; r++) begin
            drive(tbl[r].en, tbl[r].mode, tbl[r].a, tbl[r].b, tbl[r].clr);
            step();
            for (int p = 0; p < 4; p++) begin
                check($sformatf("tbl%0d.q[%0d]", r, p),   q[p],   tbl[r].q[p]);
                check($sformatf("tbl%0d.chg[%0d]", r, p), ch[p],  tbl[r].chg[p]);
                check($sformatf("tbl%0d.flg[%0d]", r, p), fl[p],  tbl[r].flg);
                check($sformatf("tbl%0d.cnt[%0d]", r, p), cnt[p], tbl[r].cnt);
            end
        end

        // Counter saturation with CNT_W=2, then clear corner cases.
        reset_pulse("rst_cnt");
        for (int k = 1; k <= 5; k++) begin
            drive(1'b1, MODE_SR, 8'h01, 8'h01, 1'b0);
            step();
            check($sformatf("sat%0d.cnt2", k), 8'(cnt2), (k < 3) ? 8'(k) : 8'd3);
            check($sformatf("sat%0d.cnt8", k), cnt[0], 8'(k));
        end
        drive(1'b1, MODE_SR, 8'h80, 8'h80, 1'b1);
        step();
        check("clr_conf.cnt2", 8'(cnt2), 8'd1);
        check("clr_conf.cnt8", cnt[0], 8'd1);
        check("clr_conf.flg",  fl[0],  8'h80);
        check("clr_conf.flg2", fl[4],  8'h80);
        drive(1'b1, MODE_SR, 8'h00, 8'h00, 1'b1);
        step();
        check("clr_only.cnt2", 8'(cnt2), 8'd0);
        check("clr_only.cnt8", cnt[0], 8'd0);
        check("clr_only.flg",  fl[0],  8'h00);
        check("clr_q2_hold",   q[4],   8'h3C);

        // Randomized run against the reference model.
        for (int n = 0; n < 400; n++) begin
            logic [7:0] ra;
            ra = 8'($urandom);
            en   = ($urandom_range(0, 7) != 0);
            mode = 2'($urandom_range(0, 3));
            a    = ra;
            b    = ($urandom_range(0, 3) == 0) ? 8'($urandom) : (~ra & 8'($urandom));
            clr  = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 59) == 0) begin
                reset_pulse($sformatf("rnd_rst%0d", n));
            end else begin
                step();
                check_model($sformatf("rnd%0d", n));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_sr_reg_bank
